// File: rtl/pipe_fetch_issue.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fetch_issue
// Description : Program-memory fetch and issue stage with RAW bubble insertion
//               against recently issued instructions and HALT detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fetch_issue #(
    parameter int IW        = 24,
    parameter int PC_W      = 8,
    parameter int HAZ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic [PC_W-1:0] ld_addr,
    input  logic [IW-1:0]   ld_data,
    input  logic            start,
    input  logic            stall,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic [3:0]      func,
    output logic [7:0]      addr,
    output logic            issue_valid,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]      c_FUNC_HALT = 4'd15;
    localparam logic [PC_W-1:0] c_PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_rs1;
    logic [3:0]      r_rs2;
    logic [3:0]      r_rd;
    logic [3:0]      r_func;
    logic [7:0]      r_addr;
    logic            r_valid;
    logic            r_busy;
    logic            r_halted;

    logic [HAZ_DEPTH-1:0] r_hist_vld;
    logic [3:0]           r_hist_rd [HAZ_DEPTH];

    logic [IW-1:0] r_mem [0:(2**PC_W)-1];

    logic [IW-1:0] w_instr;
    logic [3:0]    w_func;
    logic [3:0]    w_rd;
    logic [3:0]    w_rs1;
    logic [3:0]    w_rs2;
    logic [7:0]    w_addr;
    logic          w_use_rs1;
    logic          w_use_rs2;
    logic          w_hazard;
    logic          w_ld_ok;

    assign w_instr = r_mem[r_pc];
    assign w_func  = w_instr[IW-1  -: 4];
    assign w_rd    = w_instr[IW-5  -: 4];
    assign w_rs1   = w_instr[IW-9  -: 4];
    assign w_rs2   = w_instr[IW-13 -: 4];
    assign w_addr  = w_instr[7:0];

    // Memory is only writable while no program is executing.
    assign w_ld_ok = ld_en && (r_state != ST_RUN);

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_func)
            4'd3, 4'd8, 4'd10, 4'd11: w_use_rs1 = 1'b1;
            4'd4, 4'd9:               w_use_rs2 = 1'b1;
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (r_hist_vld[i] &&
                ((w_use_rs1 && (r_hist_rd[i] == w_rs1)) ||
                 (w_use_rs2 && (r_hist_rd[i] == w_rs2)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_func     <= '0;
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_hist_vld <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                r_hist_rd[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_pc       <= '0;
                        r_valid    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                        r_hist_vld <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (w_func == c_FUNC_HALT) begin
                            r_state  <= ST_DONE;
                            r_valid  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            // A bubble shifts in as an invalid entry so stale
                            // producers age out of the window on schedule.
                            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                                r_hist_vld[i] <= r_hist_vld[i-1];
                                r_hist_rd[i]  <= r_hist_rd[i-1];
                            end
                            r_hist_vld[0] <= ~w_hazard;
                            r_hist_rd[0]  <= w_rd;
                            if (w_hazard) begin
                                r_valid <= 1'b0;
                            end else begin
                                r_rs1   <= w_rs1;
                                r_rs2   <= w_rs2;
                                r_rd    <= w_rd;
                                r_func  <= w_func;
                                r_addr  <= w_addr;
                                r_valid <= 1'b1;
                                r_pc    <= r_pc + c_PC_ONE;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign func        = r_func;
    assign addr        = r_addr;
    assign issue_valid = r_valid;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign halted      = r_halted;

endmodule
`default_nettype wire
